// File: rtl/alu_pkg.sv
// Shared ALU opcodes, sequencer state encodings and datapath width.
package alu_pkg;
  localparam int DATA_W = 32;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_AND = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CHK  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/alu.sv
// Core's shared combinational 32-bit ALU: ADD/AND/OR/SUB with zero flag.
module alu (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero
);
  import alu_pkg::*;

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SUB: result = a - b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
endmodule

// File: rtl/alu_muldiv_seq.sv
// Unsigned MULU/DIVU sequencer that borrows the shared ALU for 32 iterations.
// ALU_SEQ_EARLY_EXIT_EN: MULU stops once the remaining multiplier bits are zero.
module alu_muldiv_seq #(
  parameter int DATA_W = 32,
  parameter int ITER   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_div,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              alu_own,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);
  import alu_pkg::*;

  localparam int CNT_W = $clog2(ITER);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              is_div;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] acc, rem, q;
  logic [DATA_W-1:0] acc_nxt, rem_nxt, q_nxt;
  logic [CNT_W-1:0]  bit_idx;
  logic [DATA_W:0]   s;
  logic              take_sub;
  logic              last;

  assign busy = (state == ST_CHK) || (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Restoring divide walks the dividend MSB first.
  assign bit_idx  = CNT_W'(ITER - 1) - cnt;
  assign s        = {rem, a_q[bit_idx]};
  assign take_sub = (s >= {1'b0, b_q});

  always_comb begin
    alu_own = 1'b0;
    alu_op  = ALU_ADD;
    alu_a   = '0;
    alu_b   = '0;
    acc_nxt = acc;
    rem_nxt = rem;
    q_nxt   = q;
    last    = (cnt == CNT_W'(ITER - 1));
    case (state)
      ST_CHK: begin
        alu_own = 1'b1;
        alu_a   = b_q;
      end
      ST_RUN: begin
        alu_own = 1'b1;
        if (is_div) begin
          alu_op = ALU_SUB;
          alu_a  = s[DATA_W-1:0];
          alu_b  = b_q;
          // s fits in 33 bits; the low-32 difference is exact when s >= divisor
          if (take_sub) begin
            rem_nxt          = alu_result;
            q_nxt[bit_idx]   = 1'b1;
          end else begin
            rem_nxt          = s[DATA_W-1:0];
          end
        end else begin
          alu_a = acc;
          alu_b = a_q << cnt;
          if (b_q[cnt]) acc_nxt = alu_result;
`ifdef ALU_SEQ_EARLY_EXIT_EN
          if ((b_q >> cnt) == '0) last = 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      rem    <= '0;
      q      <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          is_div <= op_div;
          a_q    <= opa;
          b_q    <= opb;
          state  <= ST_CHK;
        end
        ST_CHK: begin
          if (is_div && alu_zero) begin
            lo    <= '1;
            hi    <= a_q;
            state <= ST_DONE;
          end else begin
            cnt   <= '0;
            acc   <= '0;
            rem   <= '0;
            q     <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc <= acc_nxt;
          rem <= rem_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            hi    <= is_div ? rem_nxt : '0;
            lo    <= is_div ? q_nxt : acc_nxt;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq driving the real shared ALU; expected results via scoreboard.
module tb_alu_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op_div = 1'b0;
  logic [31:0] opa = '0, opb = '0;
  logic        busy, done, alu_own, alu_zero;
  logic [31:0] hi, lo, alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;

  alu_muldiv_seq #(.DATA_W(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op_div(op_div), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .alu_own(alu_own), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_zero(alu_zero)
  );

  alu u_alu (.op(alu_op), .a(alu_a), .b(alu_b), .result(alu_result), .zero(alu_zero));

  always #5 clk = ~clk;

  typedef struct { logic d; logic [31:0] a, b, lo, hi; } vec_t;
  typedef struct { logic [31:0] lo, hi; int lat; int t0; } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0;
  int   cyc = 0, ndone = 0, n_exp = 0, own_bad = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (!rst && done) ndone++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_lat(input logic d, input logic [31:0] b);
    if (d && b == 0) return 2;
`ifdef ALU_SEQ_EARLY_EXIT_EN
    if (!d) begin
      int msb = -1;
      for (int k = 0; k < 32; k++) if (b[k]) msb = k;
      return (msb < 0) ? 3 : 2 + (msb + 1) + 1;
    end
`endif
    return 34;
  endfunction

  // Returns at the negedge of cycle 1 of the new operation.
  task automatic issue(input logic d, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] elo, input logic [31:0] ehi);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op_div = d; opa = a; opb = b;
    e.lo = elo; e.hi = ehi; e.lat = exp_lat(d, b); e.t0 = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; opa = $urandom; opb = $urandom; op_div = 1'($urandom);
  endtask

  // Returns at the negedge of the DONE cycle.
  task automatic wait_result(input string tag);
    exp_t e;
    int   bc = 0, ebc;
    bit   got = 0;
    e = sb[0];
    ebc = e.lat - (cyc - e.t0);
    for (int k = 0; k < 200 && !got; k++) begin
      if (done) begin
        got = 1;
        e = sb.pop_front();
        n_exp++;
        check({tag, " lo"}, lo, e.lo);
        check({tag, " hi"}, hi, e.hi);
        check({tag, " latency"}, 32'(cyc - e.t0), 32'(e.lat));
        check({tag, " busy cycles"}, 32'(bc), 32'(ebc));
        check({tag, " busy/own in done"}, {30'd0, busy, alu_own}, 32'd0);
      end else begin
        if (busy) bc++;
        if (alu_own !== busy) own_bad++;
        @(negedge clk);
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL %s timeout: no done within 200 cycles", tag);
      void'(sb.pop_front());
    end
  endtask

  vec_t vt[$];

  initial begin
    vt.push_back('{1'b0, 32'd7,          32'd6,          32'd42,         32'd0});
    vt.push_back('{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001,   32'd0});
    vt.push_back('{1'b1, 32'd100,        32'd7,          32'd14,         32'd2});
    vt.push_back('{1'b1, 32'd5,          32'd9,          32'd0,          32'd5});
    vt.push_back('{1'b1, 32'd1234,       32'd0,          32'hFFFFFFFF,   32'd1234});
    vt.push_back('{1'b0, 32'd3,          32'd5,          32'd15,         32'd0});
    vt.push_back('{1'b0, 32'hDEAD,       32'd0,          32'd0,          32'd0});
    vt.push_back('{1'b1, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0});
    vt.push_back('{1'b1, 32'd7,          32'hFFFFFFFF,   32'd0,          32'd7});
    vt.push_back('{1'b0, 32'h00010000,   32'h00010000,   32'd0,          32'd0});
    vt.push_back('{1'b1, 32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2});
    for (int r = 0; r < 6; r++) begin
      vec_t v;
      v.d = 1'(r & 1);
      v.a = $urandom;
      v.b = (r == 5) ? 32'($urandom_range(1, 300)) : $urandom >> $urandom_range(0, 31);
      if (v.d) begin
        if (v.b == 0) v.b = 32'd1;
        v.lo = v.a / v.b; v.hi = v.a % v.b;
      end else begin
        v.lo = v.a * v.b; v.hi = 32'd0;
      end
      vt.push_back(v);
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy/done/own", {29'd0, busy, done, alu_own}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset alu_a", alu_a, 32'd0);
    check("reset alu_b", alu_b, 32'd0);
    check("reset alu_op", {28'd0, alu_op}, 32'd0);

    foreach (vt[i]) begin
      issue(vt[i].d, vt[i].a, vt[i].b, vt[i].lo, vt[i].hi);
      wait_result($sformatf("vec%0d", i));
    end
    check("alu_own tracks busy", 32'(own_bad), 32'd0);

    // start pulsed mid-MULU must be dropped
    issue(1'b0, 32'd7, 32'd6, 32'd42, 32'd0);
    repeat (9) @(negedge clk);
    start = 1'b1; op_div = 1'b1; opa = 32'd99; opb = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_result("ignored start");

    // start during DONE must be dropped
    start = 1'b1; op_div = 1'b0; opa = 32'd5; opb = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("start in done ignored", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("still idle after done-start", {31'd0, busy}, 32'd0);

    // reset mid-operation aborts with no done and clears hi/lo
    issue(1'b0, 32'h1234, 32'h80000010, 32'd0, 32'd0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_front());
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort done", {31'd0, done}, 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    repeat (40) @(negedge clk);
    check("done pulse count", 32'(ndone), 32'(n_exp));

    // sequencer still usable after abort
    issue(1'b1, 32'd100, 32'd7, 32'd14, 32'd2);
    wait_result("post-abort div");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end
endmodule
